// File: rtl/fft_out_serializer.sv
// fft_out_serializer: FFT even/odd pair to one-sample stream with sample FIFO.
// Define FFT_SER_INDEX_EN to add the m_index output and the index_err pulse.
module fft_out_serializer #(
  parameter int N          = 32,
  parameter int WORD_SIZE  = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int EN_THRESH  = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [2*WORD_SIZE-1:0] in_samp1,
  input  logic [2*WORD_SIZE-1:0] in_samp2,
  input  logic                   in_valid,
  output logic                   src_en,
  output logic [2*WORD_SIZE-1:0] m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_last,
  output logic                   busy,
  output logic                   frame_done,
`ifdef FFT_SER_INDEX_EN
  output logic [$clog2(N)-1:0]   m_index,
  output logic                   index_err,
`endif
  output logic                   overflow
);

  localparam int SW   = 2 * WORD_SIZE;
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CW   = PW + 1;
  localparam int OW   = $clog2(N);
  localparam int PRW  = $clog2(N / 2) + 1;
  localparam int HALF = N / 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PRW-1:0]  pairs_q, pairs_d;
  logic [OW-1:0]   out_cnt_q, out_cnt_d;
  logic            src_en_q, src_en_d;
  logic            ovf_q, ovf_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;
  logic [SW-1:0]   mem_q [FIFO_DEPTH];

  logic [PW-1:0]   wr_ptr_p1;
  logic [CW-1:0]   free_now;
  logic [CW-1:0]   free_nxt;
  logic            wr_ok;
  logic            drop;
  logic            accept;

  assign wr_ptr_p1 = wr_ptr_q + PW'(1);
  assign free_now  = CW'(FIFO_DEPTH) - count_q;
  assign wr_ok     = in_valid && (state_q == S_RUN)
                     && (free_now >= CW'(2));
  assign drop      = in_valid && !wr_ok;

  assign m_valid    = (count_q != '0);
  assign m_data     = m_valid ? mem_q[rd_ptr_q] : '0;
  assign m_last     = m_valid && (out_cnt_q == OW'(N - 1));
  assign accept     = m_valid && m_ready;
  assign src_en     = src_en_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign overflow   = ovf_q;

  // Next-state for FSM, pointers, counters and registered flags.
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    pairs_d   = pairs_q;
    out_cnt_d = out_cnt_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    count_d   = count_q
                + (wr_ok  ? CW'(2) : CW'(0))
                - (accept ? CW'(1) : CW'(0));
    if (drop) ovf_d = 1'b1;
    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + PW'(2);
      pairs_d  = pairs_q + PRW'(1);
    end
    if (accept) begin
      rd_ptr_d  = rd_ptr_q + PW'(1);
      out_cnt_d = out_cnt_q + OW'(1);
    end
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_RUN;
          pairs_d   = '0;
          out_cnt_d = '0;
        end
      end
      S_RUN: begin
        if (pairs_d == PRW'(HALF)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (accept && m_last) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d   = (state_d != S_IDLE);
    free_nxt = CW'(FIFO_DEPTH) - count_d;
    src_en_d = (state_d == S_RUN)
               && (free_nxt >= CW'(EN_THRESH))
               && (pairs_d < PRW'(HALF));
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      pairs_q   <= '0;
      out_cnt_q <= '0;
      src_en_q  <= 1'b0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      pairs_q   <= pairs_d;
      out_cnt_q <= out_cnt_d;
      src_en_q  <= src_en_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  // Sample storage; both halves of a pair land in one cycle.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q]  <= in_samp1;
      mem_q[wr_ptr_p1] <= in_samp2;
    end
  end

`ifdef FFT_SER_INDEX_EN
  logic idx_err_q;

  assign m_index   = out_cnt_q;
  assign index_err = idx_err_q;

  // Flag a pair beyond the frame length.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_err_q <= 1'b0;
    end else begin
      idx_err_q <= in_valid && (state_q != S_IDLE)
                   && (pairs_q == PRW'(HALF));
    end
  end
`endif

endmodule

// File: tb/tb_fft_out_serializer.sv
// tb_fft_out_serializer: directed bench for fft_out_serializer.
// Models a 2-cycle reader that answers src_en with sample pairs.
module tb_fft_out_serializer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] in_samp1;
  logic [31:0] in_samp2;
  logic        in_valid;
  logic        src_en;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic        busy;
  logic        frame_done;
  logic        overflow;
`ifdef FFT_SER_INDEX_EN
  logic [4:0]  m_index;
  logic        index_err;
`endif

  int n_chk;
  int n_pass;
  bit req0;
  bit req1;
  int issued;
  int arrived;

  fft_out_serializer #(
    .N(32), .WORD_SIZE(16), .FIFO_DEPTH(8), .EN_THRESH(6)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .in_samp1(in_samp1),
    .in_samp2(in_samp2),
    .in_valid(in_valid),
    .src_en(src_en),
    .m_data(m_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_last(m_last),
    .busy(busy),
    .frame_done(frame_done),
`ifdef FFT_SER_INDEX_EN
    .m_index(m_index),
    .index_err(index_err),
`endif
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] samp(input int fr, input int i);
    logic [7:0] iv;
    iv = 8'(i);
    return {8'(fr), 8'hC3, iv, ~iv};
  endfunction

  // mode 0: ready=1, mode 1: ready=0 for 20 cycles, mode 2: ready 1010..
  task automatic run_frame(input int fr, input int mode, input int stop_at,
                           input bit inject, input bit exp_ovf);
    int acc;
    bit held_v;
    logic [31:0] held_d;
    bit last_arr;
    bit injected;
    bit ierr_seen;
    acc = 0; held_v = 0; held_d = '0;
    last_arr = 0; injected = 0; ierr_seen = 0;
    req0 = 0; req1 = 0; issued = 0; arrived = 0;
    @(negedge clk);
    start = 1'b1;
    in_valid = 1'b0;
    m_ready = 1'b0;
    for (int cyc = 0; cyc < 400 && acc < stop_at; cyc++) begin
      @(negedge clk);
      start = (mode == 2 && cyc == 9);
      case (mode)
        0: m_ready = 1'b1;
        1: m_ready = (cyc >= 20);
        default: m_ready = (cyc % 2 == 0);
      endcase
      in_valid = req1;
      if (req1) begin
        in_samp1 = samp(fr, 2 * arrived);
        in_samp2 = samp(fr, 2 * arrived + 1);
        arrived++;
      end else if (inject && last_arr && !injected) begin
        in_valid = 1'b1;
        in_samp1 = 32'hDEAD_0001;
        in_samp2 = 32'hDEAD_0002;
        injected = 1'b1;
      end
      last_arr = (arrived == 16);
      req1 = req0;
      req0 = src_en && (issued < 16);
      if (req0) issued++;
      if (mode == 1 && cyc == 19) begin
        chk("stall_src_en", 32'(src_en), 32'd0);
        chk("stall_pairs", 32'(issued), 32'd4);
        chk("stall_ovf", 32'(overflow), 32'd0);
      end
`ifdef FFT_SER_INDEX_EN
      if (index_err) ierr_seen = 1'b1;
`endif
      if (held_v) begin
        chk("hold_valid", 32'(m_valid), 32'd1);
        chk("hold_data", m_data, held_d);
      end
      if (m_valid && m_ready) begin
        chk($sformatf("data%0d", acc), m_data, samp(fr, acc));
        chk($sformatf("last%0d", acc), 32'(m_last), 32'(acc == 31));
`ifdef FFT_SER_INDEX_EN
        chk("m_index", 32'(m_index), 32'(acc));
`endif
        acc++;
      end
      held_v = m_valid && !m_ready;
      held_d = m_data;
    end
    start = 1'b0;
    if (acc < stop_at) chk("timeout_accepts", 32'(acc), 32'(stop_at));
    if (stop_at == 32) begin
      in_valid = 1'b0;
      @(negedge clk);
      chk("frame_done", 32'(frame_done), 32'd1);
      chk("busy_end", 32'(busy), 32'd0);
      chk("valid_end", 32'(m_valid), 32'd0);
      chk("ovf_end", 32'(overflow), 32'(exp_ovf));
      @(negedge clk);
      chk("done_pulse", 32'(frame_done), 32'd0);
`ifdef FFT_SER_INDEX_EN
      if (inject) chk("index_err", 32'(ierr_seen), 32'd1);
`endif
    end
  endtask

  task automatic do_reset();
    start = 1'b0;
    in_valid = 1'b0;
    m_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    in_samp1 = '0; in_samp2 = '0;
    do_reset();
    chk("rst_src_en", 32'(src_en), 32'd0);
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_last", 32'(m_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_data", m_data, 32'd0);

    run_frame(1, 0, 32, 1'b0, 1'b0);
    run_frame(2, 1, 32, 1'b0, 1'b0);
    run_frame(3, 2, 32, 1'b0, 1'b0);

    run_frame(4, 0, 10, 1'b0, 1'b0);
    reset = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_valid", 32'(m_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_src_en", 32'(src_en), 32'd0);
    @(negedge clk);
    chk("midrst_done", 32'(frame_done), 32'd0);
    run_frame(5, 0, 32, 1'b0, 1'b0);

    @(negedge clk);
    in_valid = 1'b1;
    in_samp1 = 32'hBAD0_0000;
    in_samp2 = 32'hBAD0_0001;
    @(negedge clk);
    in_valid = 1'b0;
    chk("idle_ovf", 32'(overflow), 32'd1);
    chk("idle_valid", 32'(m_valid), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    run_frame(6, 0, 32, 1'b0, 1'b1);

    do_reset();
    chk("rst2_ovf", 32'(overflow), 32'd0);
    run_frame(7, 0, 32, 1'b1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
